// File: rtl/multi_timer_if.sv
// rtl/multi_timer_if.sv - Wishbone single-access slave bus bundle for multi_timer
interface multi_timer_if #(
    parameter int Dw   = 32,
    parameter int Aw   = 4,
    parameter int SELw = 4,
    parameter int TAGw = 3
);
    logic [Dw-1:0]   sa_dat_i;
    logic [SELw-1:0] sa_sel_i;
    logic [Aw-1:0]   sa_addr_i;
    logic [TAGw-1:0] sa_tag_i;
    logic            sa_stb_i;
    logic            sa_cyc_i;
    logic            sa_we_i;
    logic [Dw-1:0]   sa_dat_o;
    logic            sa_ack_o;
    logic            sa_err_o;
    logic            sa_rty_o;

    modport slave (
        input  sa_dat_i, sa_sel_i, sa_addr_i, sa_tag_i, sa_stb_i, sa_cyc_i, sa_we_i,
        output sa_dat_o, sa_ack_o, sa_err_o, sa_rty_o
    );

    modport master (
        output sa_dat_i, sa_sel_i, sa_addr_i, sa_tag_i, sa_stb_i, sa_cyc_i, sa_we_i,
        input  sa_dat_o, sa_ack_o, sa_err_o, sa_rty_o
    );
endinterface

// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - CH-channel prescaled timer with sticky IRQs; PWM outputs under MTIMER_PWM_EN
module multi_timer #(
    parameter int CH              = 4,
    parameter int CNTw            = 32,
    parameter int PRESCALER_WIDTH = 8,
    parameter int Dw              = 32,
    parameter int Aw              = 4,
    parameter int SELw            = 4,
    parameter int TAGw            = 3
) (
    input  logic          clk,
    input  logic          reset,
    multi_timer_if.slave  bus,
    output logic [CH-1:0] irq_ch,
    output logic          irq,
    output logic [CH-1:0] pwm_o
);
    localparam int CHw = Aw - 2;

    logic            w_access;
    logic            w_wr;
    logic [CHw-1:0]  w_ch;
    logic [1:0]      w_reg;
    logic            r_ack;
    logic [Dw-1:0]   r_dat;
    logic [Dw-1:0]   w_rdata;
    logic [Dw-1:0]   w_rd [CH];

    // Byte selects, tag and cyc carry no meaning for this full-word slave.
    logic [SELw-1:0] w_unused_sel;
    logic [TAGw-1:0] w_unused_tag;
    logic            w_unused_misc;
    assign w_unused_sel  = bus.sa_sel_i;
    assign w_unused_tag  = bus.sa_tag_i;
    assign w_unused_misc = ^{bus.sa_cyc_i, bus.sa_dat_i};

    // An access is the strobe cycle that raises ack; the following held cycle is idle.
    assign w_access = bus.sa_stb_i & ~r_ack;
    assign w_wr     = w_access & bus.sa_we_i;
    assign w_ch     = bus.sa_addr_i[Aw-1:2];
    assign w_reg    = bus.sa_addr_i[1:0];

    genvar c;
    generate
        for (c = 0; c < CH; c++) begin : g_ch
            logic                       r_en;
            logic                       r_int_en;
            logic                       r_rst_on_cmp;
            logic                       r_one_shot;
            logic                       r_isr;
            logic [CNTw-1:0]            r_count;
            logic [CNTw-1:0]            r_cmp;
            logic [PRESCALER_WIDTH-1:0] r_presc;
            logic [PRESCALER_WIDTH-1:0] r_pcnt;
            logic                       w_sel;
            logic                       w_tick;
            logic                       w_match;
            logic                       w_pwm_bit;

            assign w_sel     = w_wr && (w_ch == CHw'(c));
            assign w_tick    = r_en && (r_pcnt == r_presc);
            assign w_match   = w_tick && (r_count == r_cmp);
            assign irq_ch[c] = r_isr & r_int_en;

            // Prescaler, counter, compare and control state; later statements take priority.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_en         <= 1'b0;
                    r_int_en     <= 1'b0;
                    r_rst_on_cmp <= 1'b0;
                    r_one_shot   <= 1'b0;
                    r_isr        <= 1'b0;
                    r_count      <= '0;
                    r_cmp        <= '1;
                    r_presc      <= '0;
                    r_pcnt       <= '0;
                end else begin
                    // pcnt is not cleared by a PRESC write, so it may run the long way round.
                    if (!r_en || w_tick) r_pcnt <= '0;
                    else                 r_pcnt <= r_pcnt + PRESCALER_WIDTH'(1);

                    if (w_sel && w_reg == 2'd1)
                        r_count <= bus.sa_dat_i[CNTw-1:0];
                    else if (w_tick)
                        r_count <= (w_match && r_rst_on_cmp) ? '0 : r_count + CNTw'(1);

                    if (w_sel && w_reg == 2'd2) r_cmp   <= bus.sa_dat_i[CNTw-1:0];
                    if (w_sel && w_reg == 2'd3) r_presc <= bus.sa_dat_i[PRESCALER_WIDTH-1:0];

                    if (w_sel && w_reg == 2'd0) begin
                        r_en         <= bus.sa_dat_i[0];
                        r_int_en     <= bus.sa_dat_i[1];
                        r_rst_on_cmp <= bus.sa_dat_i[2];
                        r_one_shot   <= bus.sa_dat_i[3];
                        if (bus.sa_dat_i[4] || !bus.sa_dat_i[1]) r_isr <= 1'b0;
                    end

                    // A match overrides same-cycle writes: one-shot stops, isr sets.
                    if (w_match && r_one_shot) r_en  <= 1'b0;
                    if (w_match && r_int_en)   r_isr <= 1'b1;
                end
            end

`ifdef MTIMER_PWM_EN
            logic r_pwm_en;
            logic r_pwm;

            // PWM enable bit and PWM output registered from the current count/compare.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_pwm_en <= 1'b0;
                    r_pwm    <= 1'b0;
                end else begin
                    if (w_sel && w_reg == 2'd0) r_pwm_en <= bus.sa_dat_i[5];
                    r_pwm <= r_en & r_pwm_en & (r_count < r_cmp);
                end
            end

            assign pwm_o[c]  = r_pwm;
            assign w_pwm_bit = r_pwm_en;
`else
            assign pwm_o[c]  = 1'b0;
            assign w_pwm_bit = 1'b0;
`endif

            assign w_rd[c] = (w_reg == 2'd0) ? Dw'({w_pwm_bit, r_isr, r_one_shot,
                                                     r_rst_on_cmp, r_int_en, r_en}) :
                             (w_reg == 2'd1) ? Dw'(r_count) :
                             (w_reg == 2'd2) ? Dw'(r_cmp)   : Dw'(r_presc);
        end
    endgenerate

    // Select the addressed channel's register; unmapped channel slots read as zero.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < CH; i++) begin
            if (w_ch == CHw'(i)) w_rdata = w_rd[i];
        end
    end

    // Ack every other cycle under a held strobe; read data captured with the ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= bus.sa_stb_i & ~r_ack;
            if (w_access && !bus.sa_we_i) r_dat <= w_rdata;
        end
    end

    assign bus.sa_ack_o = r_ack;
    assign bus.sa_dat_o = r_dat;
    assign bus.sa_err_o = 1'b0;
    assign bus.sa_rty_o = 1'b0;
    assign irq          = |irq_ch;
endmodule
